// File: rtl/mips_muldiv_pkg.sv
// Shared definitions for the MIPS iterative multiply/divide unit:
// operation encodings, FSM state type and HI/LO write-select values.
package mips_muldiv_pkg;

    // op[1] selects divide, op[0] selects signed arithmetic
    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    localparam logic HILO_SEL_LO = 1'b0;
    localparam logic HILO_SEL_HI = 1'b1;

endpackage

// File: rtl/mips_muldiv_step.sv
// One iteration of the multiply/divide datapath (purely combinational).
// Multiply: shift-add, BITS_PER_CYCLE multiplier bits consumed from the LSB
//   end of qr_i; {acc, qr} shifts right so it ends up holding the product.
// Divide (only when MULDIV_DIV_EN is defined): restoring division,
//   BITS_PER_CYCLE dividend bits shifted out of the MSB of qr_i into the
//   partial remainder acc, quotient bits shifted into the LSB of qr.
module mips_muldiv_step #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
`ifdef MULDIV_DIV_EN
    input  logic             is_div_i,
`endif
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] qr_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] qr_o
);

    localparam int PW = WIDTH + BITS_PER_CYCLE;

    logic [PW-1:0]    sum;
    logic [WIDTH-1:0] mul_acc;
    logic [WIDTH-1:0] mul_qr;

    // Shift-add: add multiplicand * (low BITS_PER_CYCLE bits of multiplier)
    always_comb begin
        sum = {{BITS_PER_CYCLE{1'b0}}, acc_i};
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            if (qr_i[j]) begin
                sum = sum + ({{BITS_PER_CYCLE{1'b0}}, b_i} << j);
            end
        end
        mul_acc = sum[PW-1:BITS_PER_CYCLE];
        mul_qr  = {sum[BITS_PER_CYCLE-1:0], qr_i[WIDTH-1:BITS_PER_CYCLE]};
    end

`ifdef MULDIV_DIV_EN
    logic [WIDTH:0]   t;
    logic [WIDTH-1:0] div_r;
    logic [WIDTH-1:0] div_q;

    // Restoring subtract: partial remainder needs one extra bit after the shift
    always_comb begin
        t     = '0;
        div_r = acc_i;
        div_q = qr_i;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            t     = {div_r, div_q[WIDTH-1]};
            div_q = {div_q[WIDTH-2:0], 1'b0};
            if (t >= {1'b0, b_i}) begin
                t        = t - {1'b0, b_i};
                div_q[0] = 1'b1;
            end
            div_r = t[WIDTH-1:0];
        end
    end

    // Select the active operation's next iteration state
    always_comb begin
        acc_o = is_div_i ? div_r : mul_acc;
        qr_o  = is_div_i ? div_q : mul_qr;
    end
`else
    // Multiply-only build: the divider path does not exist
    always_comb begin
        acc_o = mul_acc;
        qr_o  = mul_qr;
    end
`endif

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// Build option: define MULDIV_DIV_EN to include DIV/DIVU; without it, a
// start with op[1]=1 is ignored and no divider logic is generated.
//
// Handshake: start is a request that is accepted on a rising edge only while
// busy is low (busy is the inverse of ready); a request seen while busy is
// dropped, not queued. done pulses for one cycle when HI/LO receive a result.
module mips_muldiv_unit
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             hilo_we,
    input  logic             hilo_sel,
    input  logic [WIDTH-1:0] hilo_wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             dbg_state_o
);

    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(N);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [WIDTH-1:0]     acc_q;
    logic [WIDTH-1:0]     qr_q;
    logic [WIDTH-1:0]     b_q;
    logic                 neg_res_q;   // negate product / quotient at the end
    logic                 done_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;
`ifdef MULDIV_DIV_EN
    logic                 is_div_q;
    logic                 neg_a_q;     // remainder takes the dividend's sign
    logic                 b_zero;
`endif

    logic                 op_ok;
    logic                 accept;
    logic                 last;
    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic                 neg_res_d;
    logic [WIDTH-1:0]     acc_nxt;
    logic [WIDTH-1:0]     qr_nxt;
    logic [2*WIDTH-1:0]   prod;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     res_hi;
    logic [WIDTH-1:0]     res_lo;

    // Decode start acceptance and sign-condition the operands to magnitudes
    always_comb begin
`ifdef MULDIV_DIV_EN
        op_ok     = 1'b1;
        b_zero    = (srcb == '0);
`else
        op_ok     = ~op[1];
`endif
        accept    = (state_q == S_IDLE) && start && op_ok;
        last      = (state_q == S_RUN) && (cnt_q == CNT_ONE);
        a_neg     = op[0] & srca[WIDTH-1];
        b_neg     = op[0] & srcb[WIDTH-1];
        mag_a     = a_neg ? -srca : srca;
        mag_b     = b_neg ? -srcb : srcb;
        neg_res_d = a_neg ^ b_neg;
`ifdef MULDIV_DIV_EN
        // Divide by zero keeps the all-ones quotient unsigned
        if (op[1] && b_zero) begin
            neg_res_d = 1'b0;
        end
`endif
    end

    mips_muldiv_step #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
`ifdef MULDIV_DIV_EN
        .is_div_i (is_div_q),
`endif
        .acc_i    (acc_q),
        .qr_i     (qr_q),
        .b_i      (b_q),
        .acc_o    (acc_nxt),
        .qr_o     (qr_nxt)
    );

    // Apply the sign fix-up to the final iteration's result
    always_comb begin
        prod     = {acc_nxt, qr_nxt};
        prod_fix = neg_res_q ? -prod : prod;
        res_hi   = prod_fix[2*WIDTH-1:WIDTH];
        res_lo   = prod_fix[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
        if (is_div_q) begin
            res_lo = neg_res_q ? -qr_nxt : qr_nxt;
            res_hi = neg_a_q ? -acc_nxt : acc_nxt;
        end
`endif
    end

    // Control FSM: latch operands on accept, iterate N edges, pulse done
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            qr_q      <= '0;
            b_q       <= '0;
            neg_res_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef MULDIV_DIV_EN
            is_div_q  <= 1'b0;
            neg_a_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_q   <= S_RUN;
                        cnt_q     <= CNT_INIT;
                        acc_q     <= '0;
                        qr_q      <= mag_a;
                        b_q       <= mag_b;
                        neg_res_q <= neg_res_d;
`ifdef MULDIV_DIV_EN
                        is_div_q  <= op[1];
                        neg_a_q   <= a_neg;
`endif
                    end
                end
                S_RUN: begin
                    acc_q <= acc_nxt;
                    qr_q  <= qr_nxt;
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // HI/LO: operation result on the last iteration, direct writes only when idle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (last) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
        end else if ((state_q == S_IDLE) && hilo_we) begin
            if (hilo_sel == HILO_SEL_HI) begin
                hi_q <= hilo_wdata;
            end else begin
                lo_q <= hilo_wdata;
            end
        end
    end

    assign busy        = (state_q == S_RUN);
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign dbg_state_o = (state_q == S_RUN);

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed-vector bench for mips_muldiv_unit (WIDTH=32). A second instance
// with BITS_PER_CYCLE=4 covers the multi-bit iteration. Divide vectors are
// used when MULDIV_DIV_EN is defined; otherwise the ignored-DIV behaviour
// is exercised instead.
module tb_mips_muldiv_unit;
    import mips_muldiv_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        hilo_we;
    logic        hilo_sel;
    logic [31:0] hilo_wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbg;

    logic        start4;
    logic [1:0]  op4;
    logic [31:0] a4;
    logic [31:0] b4;
    logic        busy4;
    logic        done4;
    logic [31:0] hi4;
    logic [31:0] lo4;
    logic        dbg4;

    int vec_cnt;
    int err_cnt;

    mips_muldiv_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
        .clk(clk), .reset(rst_n), .start(start), .op(op), .srca(srca), .srcb(srcb),
        .hilo_we(hilo_we), .hilo_sel(hilo_sel), .hilo_wdata(hilo_wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .dbg_state_o(dbg)
    );

    mips_muldiv_unit #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .reset(rst_n), .start(start4), .op(op4), .srca(a4), .srcb(b4),
        .hilo_we(1'b0), .hilo_sel(1'b0), .hilo_wdata(32'h0),
        .busy(busy4), .done(done4), .hi(hi4), .lo(lo4), .dbg_state_o(dbg4)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one operation from a negedge; returns at the negedge where done is
    // seen. lat counts edges with the accepting edge as 1. inj>0 injects a
    // start (1*1) and a LO write while busy at that latency count. we0 writes
    // HI with wd0 in the same cycle as the start.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int inj, input logic we0, input logic [31:0] wd0,
                         output int lat, output int busy_n, output logic [31:0] hi_e0);
        start = 1'b1; op = o; srca = a; srcb = b;
        hilo_we = we0; hilo_sel = HILO_SEL_HI; hilo_wdata = wd0;
        lat = 0; busy_n = 0;
        @(posedge clk); lat = 1;
        @(negedge clk); start = 1'b0; hilo_we = 1'b0;
        hi_e0 = hi;
        for (int k = 0; k < 100; k++) begin
            if (done) break;
            if (busy) busy_n++;
            if (inj != 0 && lat == inj) begin
                start = 1'b1; op = OP_MULTU; srca = 32'd1; srcb = 32'd1;
                hilo_we = 1'b1; hilo_sel = HILO_SEL_LO; hilo_wdata = 32'h1234;
            end
            @(posedge clk); lat++;
            @(negedge clk); start = 1'b0; hilo_we = 1'b0;
        end
    endtask

    task automatic test_reset();
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b want 0", busy); end
        vec_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL reset_done: got %b want 0", done); end
        vec_cnt++; if (hi !== 32'h0) begin err_cnt++; $display("FAIL reset_hi: got %h want 00000000", hi); end
        vec_cnt++; if (lo !== 32'h0) begin err_cnt++; $display("FAIL reset_lo: got %h want 00000000", lo); end
        vec_cnt++; if (dbg !== 1'b0) begin err_cnt++; $display("FAIL reset_state: got %b want 0", dbg); end
    endtask

    task automatic test_multu();
        int lat, bn; logic [31:0] h0;
        do_op(OP_MULTU, 32'hFFFFFFFF, 32'h2, 0, 1'b0, 32'h0, lat, bn, h0);
        vec_cnt++; if (lat !== 33) begin err_cnt++; $display("FAIL multu_latency: got %0d want 33", lat); end
        vec_cnt++; if (bn !== 32) begin err_cnt++; $display("FAIL multu_busy_cycles: got %0d want 32", bn); end
        vec_cnt++; if (hi !== 32'h1) begin err_cnt++; $display("FAIL multu_hi: got %h want 00000001", hi); end
        vec_cnt++; if (lo !== 32'hFFFFFFFE) begin err_cnt++; $display("FAIL multu_lo: got %h want fffffffe", lo); end
        @(negedge clk);
        vec_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL multu_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_mult();
        int lat, bn; logic [31:0] h0;
        do_op(OP_MULT, 32'hFFFFFFFD, 32'h5, 0, 1'b0, 32'h0, lat, bn, h0);
        vec_cnt++; if (hi !== 32'hFFFFFFFF) begin err_cnt++; $display("FAIL mult_neg3x5_hi: got %h want ffffffff", hi); end
        vec_cnt++; if (lo !== 32'hFFFFFFF1) begin err_cnt++; $display("FAIL mult_neg3x5_lo: got %h want fffffff1", lo); end
        do_op(OP_MULT, 32'h80000000, 32'h80000000, 0, 1'b0, 32'h0, lat, bn, h0);
        vec_cnt++; if (hi !== 32'h40000000) begin err_cnt++; $display("FAIL mult_min_sq_hi: got %h want 40000000", hi); end
        vec_cnt++; if (lo !== 32'h0) begin err_cnt++; $display("FAIL mult_min_sq_lo: got %h want 00000000", lo); end
        do_op(OP_MULT, 32'h7, 32'hFFFFFFFA, 0, 1'b0, 32'h0, lat, bn, h0);
        vec_cnt++; if (hi !== 32'hFFFFFFFF) begin err_cnt++; $display("FAIL mult_7xneg6_hi: got %h want ffffffff", hi); end
        vec_cnt++; if (lo !== 32'hFFFFFFD6) begin err_cnt++; $display("FAIL mult_7xneg6_lo: got %h want ffffffd6", lo); end
    endtask

    task automatic test_busy_ignore();
        int lat, bn; logic [31:0] h0;
        do_op(OP_MULTU, 32'hFFFFFFFF, 32'h2, 5, 1'b0, 32'h0, lat, bn, h0);
        vec_cnt++; if (lat !== 33) begin err_cnt++; $display("FAIL busy_ignore_latency: got %0d want 33", lat); end
        vec_cnt++; if (hi !== 32'h1) begin err_cnt++; $display("FAIL busy_ignore_hi: got %h want 00000001", hi); end
        vec_cnt++; if (lo !== 32'hFFFFFFFE) begin err_cnt++; $display("FAIL busy_ignore_lo: got %h want fffffffe", lo); end
    endtask

    task automatic test_hilo_write();
        int lat, bn; logic [31:0] h0;
        hilo_we = 1'b1; hilo_sel = HILO_SEL_HI; hilo_wdata = 32'hCAFE0000;
        @(negedge clk); hilo_we = 1'b0;
        vec_cnt++; if (hi !== 32'hCAFE0000) begin err_cnt++; $display("FAIL mthi_hi: got %h want cafe0000", hi); end
        vec_cnt++; if (lo !== 32'hFFFFFFFE) begin err_cnt++; $display("FAIL mthi_lo_kept: got %h want fffffffe", lo); end
        hilo_we = 1'b1; hilo_sel = HILO_SEL_LO; hilo_wdata = 32'h00001234;
        @(negedge clk); hilo_we = 1'b0;
        vec_cnt++; if (lo !== 32'h00001234) begin err_cnt++; $display("FAIL mtlo_lo: got %h want 00001234", lo); end
        vec_cnt++; if (hi !== 32'hCAFE0000) begin err_cnt++; $display("FAIL mtlo_hi_kept: got %h want cafe0000", hi); end
        do_op(OP_MULTU, 32'd6, 32'd7, 0, 1'b1, 32'hDEAD0000, lat, bn, h0);
        vec_cnt++; if (h0 !== 32'hDEAD0000) begin err_cnt++; $display("FAIL we_with_start_hi: got %h want dead0000", h0); end
        vec_cnt++; if (hi !== 32'h0) begin err_cnt++; $display("FAIL we_with_start_res_hi: got %h want 00000000", hi); end
        vec_cnt++; if (lo !== 32'd42) begin err_cnt++; $display("FAIL we_with_start_res_lo: got %h want 0000002a", lo); end
    endtask

    task automatic test_back_to_back();
        int lat, bn; logic [31:0] h0;
        do_op(OP_MULTU, 32'h00010000, 32'h00010000, 0, 1'b0, 32'h0, lat, bn, h0);
        vec_cnt++; if (hi !== 32'h1 || lo !== 32'h0) begin err_cnt++; $display("FAIL b2b_first: got %h_%h want 00000001_00000000", hi, lo); end
        // started in the done cycle of the previous op
        do_op(OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0, 32'h0, lat, bn, h0);
        vec_cnt++; if (lat !== 33) begin err_cnt++; $display("FAIL b2b_latency: got %0d want 33", lat); end
        vec_cnt++; if (hi !== 32'h0) begin err_cnt++; $display("FAIL b2b_hi: got %h want 00000000", hi); end
        vec_cnt++; if (lo !== 32'h1) begin err_cnt++; $display("FAIL b2b_lo: got %h want 00000001", lo); end
    endtask

`ifdef MULDIV_DIV_EN
    task automatic test_div();
        int lat, bn; logic [31:0] h0;
        do_op(OP_DIV, 32'hFFFFFFF9, 32'h2, 0, 1'b0, 32'h0, lat, bn, h0);
        vec_cnt++; if (lat !== 33) begin err_cnt++; $display("FAIL div_latency: got %0d want 33", lat); end
        vec_cnt++; if (lo !== 32'hFFFFFFFD) begin err_cnt++; $display("FAIL div_m7_2_lo: got %h want fffffffd", lo); end
        vec_cnt++; if (hi !== 32'hFFFFFFFF) begin err_cnt++; $display("FAIL div_m7_2_hi: got %h want ffffffff", hi); end
        do_op(OP_DIVU, 32'h9, 32'h0, 0, 1'b0, 32'h0, lat, bn, h0);
        vec_cnt++; if (lat !== 33) begin err_cnt++; $display("FAIL divu_zero_latency: got %0d want 33", lat); end
        vec_cnt++; if (lo !== 32'hFFFFFFFF) begin err_cnt++; $display("FAIL divu_zero_lo: got %h want ffffffff", lo); end
        vec_cnt++; if (hi !== 32'h9) begin err_cnt++; $display("FAIL divu_zero_hi: got %h want 00000009", hi); end
        do_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 0, 1'b0, 32'h0, lat, bn, h0);
        vec_cnt++; if (lo !== 32'h80000000) begin err_cnt++; $display("FAIL div_ovf_lo: got %h want 80000000", lo); end
        vec_cnt++; if (hi !== 32'h0) begin err_cnt++; $display("FAIL div_ovf_hi: got %h want 00000000", hi); end
        do_op(OP_DIV, 32'h7, 32'hFFFFFFFE, 0, 1'b0, 32'h0, lat, bn, h0);
        vec_cnt++; if (lo !== 32'hFFFFFFFD) begin err_cnt++; $display("FAIL div_7_m2_lo: got %h want fffffffd", lo); end
        vec_cnt++; if (hi !== 32'h1) begin err_cnt++; $display("FAIL div_7_m2_hi: got %h want 00000001", hi); end
        do_op(OP_DIVU, 32'hFFFFFFFF, 32'h10, 0, 1'b0, 32'h0, lat, bn, h0);
        vec_cnt++; if (lo !== 32'h0FFFFFFF) begin err_cnt++; $display("FAIL divu_big_lo: got %h want 0fffffff", lo); end
        vec_cnt++; if (hi !== 32'hF) begin err_cnt++; $display("FAIL divu_big_hi: got %h want 0000000f", hi); end
    endtask
`else
    task automatic test_div_absent();
        int bn, dn; logic [31:0] h_before, l_before;
        h_before = hi; l_before = lo; bn = 0; dn = 0;
        start = 1'b1; op = OP_DIV; srca = 32'hFFFFFFF9; srcb = 32'h2;
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (busy) bn++;
            if (done) dn++;
            @(negedge clk);
        end
        vec_cnt++; if (bn !== 0) begin err_cnt++; $display("FAIL nodiv_busy: got %0d busy cycles want 0", bn); end
        vec_cnt++; if (dn !== 0) begin err_cnt++; $display("FAIL nodiv_done: got %0d done cycles want 0", dn); end
        vec_cnt++; if (hi !== h_before || lo !== l_before) begin err_cnt++; $display("FAIL nodiv_hilo: got %h_%h want %h_%h", hi, lo, h_before, l_before); end
    endtask
`endif

    task automatic test_reset_abort();
        int lat, bn; logic [31:0] h0;
        start = 1'b1; op = OP_MULT; srca = 32'hFFFFFFFD; srcb = 32'h5;
        @(negedge clk); start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL abort_busy: got %b want 0", busy); end
        vec_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL abort_done: got %b want 0", done); end
        vec_cnt++; if (hi !== 32'h0) begin err_cnt++; $display("FAIL abort_hi: got %h want 00000000", hi); end
        vec_cnt++; if (lo !== 32'h0) begin err_cnt++; $display("FAIL abort_lo: got %h want 00000000", lo); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        do_op(OP_MULTU, 32'd6, 32'd7, 0, 1'b0, 32'h0, lat, bn, h0);
        vec_cnt++; if (lo !== 32'd42) begin err_cnt++; $display("FAIL after_abort_lo: got %h want 0000002a", lo); end
        vec_cnt++; if (hi !== 32'h0) begin err_cnt++; $display("FAIL after_abort_hi: got %h want 00000000", hi); end
    endtask

    task automatic test_bpc4();
        int lat;
        start4 = 1'b1; op4 = OP_MULTU; a4 = 32'h12345678; b4 = 32'h9ABCDEF0;
        lat = 0;
        @(posedge clk); lat = 1;
        @(negedge clk); start4 = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done4) break;
            @(posedge clk); lat++;
            @(negedge clk);
        end
        vec_cnt++; if (lat !== 9) begin err_cnt++; $display("FAIL bpc4_latency: got %0d want 9", lat); end
        vec_cnt++; if (hi4 !== 32'h0B00EA4E) begin err_cnt++; $display("FAIL bpc4_hi: got %h want 0b00ea4e", hi4); end
        vec_cnt++; if (lo4 !== 32'h242D2080) begin err_cnt++; $display("FAIL bpc4_lo: got %h want 242d2080", lo4); end
    endtask

    initial begin
        vec_cnt = 0; err_cnt = 0;
        rst_n = 1'b0; start = 1'b0; op = 2'b00; srca = '0; srcb = '0;
        hilo_we = 1'b0; hilo_sel = 1'b0; hilo_wdata = '0;
        start4 = 1'b0; op4 = 2'b00; a4 = '0; b4 = '0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_multu();
        test_mult();
        test_busy_ignore();
        test_hilo_write();
        test_back_to_back();
`ifdef MULDIV_DIV_EN
        test_div();
`else
        test_div_absent();
`endif
        test_reset_abort();
        test_bpc4();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
